xtea_keyex_pipe: RTL

- Parametrised next-generation XTEA round-key expander.
- Produces the per-round subkey pairs ka[i] = sum_i + K[sum_i[1:0]] and kb[i] = sum_{i+1} + K[sum_{i+1}[12:11]], where sum_i = i*DELTA mod 2^32.
- Configurable round count, rounds per cycle, and encrypt/decrypt storage order. Supports restart and abort while busy.
- Sits between the key-load interface and the XTEA round datapath; the datapath consumes o_exkey_a/o_exkey_b once o_key_ok is high.

---
 rtl/xtea_keyex_pipe_if.sv | 30 +++
 rtl/xtea_keyex_pipe.sv | 127 ++++++++++++
 2 files changed

// File: rtl/xtea_keyex_pipe_if.sv
// Key-load / schedule bus for xtea_keyex_pipe.
// XTEA_KEYEX_ZEROIZE_EN adds the i_zeroize request line.
`timescale 1ns/1ps
interface xtea_keyex_pipe_if #(
  parameter int unsigned ROUNDS = 32
);
  logic [127:0]         i_key;
  logic                 i_key_en;
  logic                 i_dec;
`ifdef XTEA_KEYEX_ZEROIZE_EN
  logic                 i_zeroize;
`endif
  logic [32*ROUNDS-1:0] o_exkey_a;
  logic [32*ROUNDS-1:0] o_exkey_b;
  logic [31:0]          o_sum_end;
  logic                 o_busy;
  logic                 o_key_ok;

`ifdef XTEA_KEYEX_ZEROIZE_EN
  modport master (output i_key, i_key_en, i_dec, i_zeroize,
                  input  o_exkey_a, o_exkey_b, o_sum_end, o_busy, o_key_ok);
  modport slave  (input  i_key, i_key_en, i_dec, i_zeroize,
                  output o_exkey_a, o_exkey_b, o_sum_end, o_busy, o_key_ok);
`else
  modport master (output i_key, i_key_en, i_dec,
                  input  o_exkey_a, o_exkey_b, o_sum_end, o_busy, o_key_ok);
  modport slave  (input  i_key, i_key_en, i_dec,
                  output o_exkey_a, o_exkey_b, o_sum_end, o_busy, o_key_ok);
`endif
endinterface

// File: rtl/xtea_keyex_pipe.sv
// XTEA round-key expander: LANES rounds per clock into encrypt- or decrypt-ordered slots.
// Optional XTEA_KEYEX_ZEROIZE_EN adds a key-material wipe via bus.i_zeroize.
`timescale 1ns/1ps
module xtea_keyex_pipe #(
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned LANES  = 1,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  xtea_keyex_pipe_if.slave  bus
);

  localparam int unsigned IW       = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [IW-1:0] LAST_CNT = IW'(ROUNDS - LANES);
  localparam logic [IW-1:0] CNT_STEP = IW'(LANES);
  localparam logic [IW-1:0] TOP_SLOT = IW'(ROUNDS - 1);
  localparam logic [31:0] SUM_STEP = LANES * DELTA;
  localparam logic [31:0] SUM_END  = ROUNDS * DELTA;

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;

  state_t          state_q;
  logic [IW-1:0]   cnt_q;
  logic [31:0]     sum_q;
  logic [127:0]    key_q;
  logic            dec_q;
  logic            key_ok_q;
  logic            busy_q;
  logic [31:0]     exa_q [ROUNDS];
  logic [31:0]     exb_q [ROUNDS];

  logic [31:0]     lane_sum  [LANES];
  logic [31:0]     lane_sumn [LANES];
  logic [31:0]     lane_ka   [LANES];
  logic [31:0]     lane_kb   [LANES];
  logic [IW-1:0]   lane_rnd  [LANES];
  logic [IW-1:0]   lane_slot [LANES];

  function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] idx);
    case (idx)
      2'd0:    return k[127:96];
      2'd1:    return k[95:64];
      2'd2:    return k[63:32];
      default: return k[31:0];
    endcase
  endfunction

  // Lane l works on round cnt+l with sum_q + l*DELTA; kb uses the following sum.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_sum[l]  = sum_q + DELTA * l;
      lane_sumn[l] = lane_sum[l] + DELTA;
      lane_ka[l]   = lane_sum[l]  + key_word(key_q, lane_sum[l][1:0]);
      lane_kb[l]   = lane_sumn[l] + key_word(key_q, lane_sumn[l][12:11]);
      lane_rnd[l]  = cnt_q + IW'(l);
      lane_slot[l] = dec_q ? (TOP_SLOT - lane_rnd[l]) : lane_rnd[l];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sum_q    <= '0;
      key_q    <= '0;
      dec_q    <= 1'b0;
      key_ok_q <= 1'b0;
      busy_q   <= 1'b0;
      for (int unsigned j = 0; j < ROUNDS; j++) begin
        exa_q[j] <= '0;
        exb_q[j] <= '0;
      end
    end else begin
`ifdef XTEA_KEYEX_ZEROIZE_EN
      if (bus.i_zeroize) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        sum_q    <= '0;
        key_q    <= '0;
        key_ok_q <= 1'b0;
        busy_q   <= 1'b0;
        for (int unsigned j = 0; j < ROUNDS; j++) begin
          exa_q[j] <= '0;
          exb_q[j] <= '0;
        end
      end else
`endif
      begin
        // A strobe in any state (re)starts expansion; in EXPAND it is an abort.
        if (bus.i_key_en) begin
          state_q  <= ST_EXPAND;
          key_q    <= bus.i_key;
          dec_q    <= bus.i_dec;
          cnt_q    <= '0;
          sum_q    <= '0;
          key_ok_q <= 1'b0;
          busy_q   <= 1'b1;
        end else if (state_q == ST_EXPAND) begin
          for (int unsigned l = 0; l < LANES; l++) begin
            exa_q[lane_slot[l]] <= lane_ka[l];
            exb_q[lane_slot[l]] <= lane_kb[l];
          end
          sum_q <= sum_q + SUM_STEP;
          if (cnt_q == LAST_CNT) begin
            state_q  <= ST_DONE;
            cnt_q    <= '0;
            key_ok_q <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_STEP;
          end
        end
      end
    end
  end

  for (genvar j = 0; j < ROUNDS; j++) begin : g_pack
    assign bus.o_exkey_a[32*(ROUNDS-j)-1 -: 32] = exa_q[j];
    assign bus.o_exkey_b[32*(ROUNDS-j)-1 -: 32] = exb_q[j];
  end

  assign bus.o_sum_end = SUM_END;
  assign bus.o_busy    = busy_q;
  assign bus.o_key_ok  = key_ok_q & ~bus.i_key_en;

endmodule
